// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// State encoding, default widths, port indices and the tie-break helper.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;
   localparam int NUM_PORTS  = 2;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_RDWAIT = 2'd2
   } arb_state_e;

   // last names the port granted most recently; a tie goes to the other one.
   function automatic logic rr_winner(input logic req0, input logic req1, input logic last);
      return req1 & ~(req0 & last);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and datamemory signals of the arbiter, bundled with directional views.
// slave = arbiter side, master = requesters plus memory side.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_dataIn;
   logic [DATA_W-1:0] mem_dataOut;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataOut,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_address, mem_dataIn
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataOut,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_address, mem_dataIn
   );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way winner select: a lone request wins, a tie goes to the port not granted last.
// Feeding last=1 permanently turns this into fixed priority for port 0.
module dmem_rr_pick
   import dmem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic sel,
   output logic valid
);

   assign valid = req0 | req1;
   assign sel   = rr_winner(req0, req1, last);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and debug/DMA (port 1) accesses onto one synchronous datamemory.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   arb_state_e             state_q, state_d;
   logic                   sel_q, sel_d;
   logic                   we_q, we_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
   logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
   logic                   mem_we_q, mem_we_d;
   logic                   last;
   logic                   pick_sel, pick_valid;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign last = PORT1;
`else
   logic                   last_q, last_d;
   assign last = last_q;
`endif

   dmem_rr_pick u_pick (
      .req0  (bus.req0),
      .req1  (bus.req1),
      .last  (last),
      .sel   (pick_sel),
      .valid (pick_valid)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      gnt_d    = '0;
      rvalid_d = '0;
      mem_we_d = 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_d   = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d         = ST_ISSUE;
               sel_d           = pick_sel;
               we_d            = pick_sel ? bus.we1    : bus.we0;
               addr_d          = pick_sel ? bus.addr1  : bus.addr0;
               wdata_d         = pick_sel ? bus.wdata1 : bus.wdata0;
               gnt_d[pick_sel] = 1'b1;
               mem_we_d        = we_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
               last_d          = pick_sel;
`endif
            end
         end
         ST_ISSUE:  state_d = we_q ? ST_IDLE : ST_RDWAIT;
         // memory data for the address issued last cycle is valid now
         ST_RDWAIT: begin
            rdata_d         = bus.mem_dataOut;
            rvalid_d[sel_q] = 1'b1;
            state_d         = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= PORT0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         mem_we_q <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_q   <= PORT1;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         mem_we_q <= mem_we_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_q   <= last_d;
`endif
      end
   end

   assign bus.gnt0        = gnt_q[PORT0];
   assign bus.gnt1        = gnt_q[PORT1];
   assign bus.rvalid0     = rvalid_q[PORT0];
   assign bus.rvalid1     = rvalid_q[PORT1];
   assign bus.rdata       = rdata_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_address = addr_q;
   assign bus.mem_dataIn  = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous datamemory.
// Honours DMEM_ARB_FIXED_PRIO_EN when computing expected tie winners.
module tb_dmem_arbiter;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [1024];
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_address] <= bus.mem_dataIn;
      bus.mem_dataOut <= mem[bus.mem_address];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, "_gnt"},    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      check({tag, "_rvalid"}, {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      check({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
   endtask

   task automatic do_write(input logic port, input logic [9:0] a, input logic [31:0] d);
      if (port) begin
         bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = a; bus.wdata0 = d;
      end
      tick();
      check("wr_gnt", {30'd0, bus.gnt1, bus.gnt0}, port ? 32'd2 : 32'd1);
      check("wr_mem_we", {31'd0, bus.mem_we}, 32'd1);
      check("wr_addr", {22'd0, bus.mem_address}, {22'd0, a});
      check("wr_data", bus.mem_dataIn, d);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      tick();
      check_idle_outs("wr_done");
   endtask

   logic exp_port;

   initial begin
      rst_n = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      #2 rst_n = 1'b0;
      tick(); tick();
      check_idle_outs("rst");
      check("rst_addr",  {22'd0, bus.mem_address}, 32'd0);
      check("rst_din",   bus.mem_dataIn, 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      rst_n = 1'b1;
      tick();
      check_idle_outs("idle");

      // single write from port 0
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'd5; bus.wdata0 = 32'hAA;
      tick();
      check("w5_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      check("w5_mem_we", {31'd0, bus.mem_we}, 32'd1);
      check("w5_addr", {22'd0, bus.mem_address}, 32'd5);
      check("w5_data", bus.mem_dataIn, 32'hAA);
      bus.req0 = 0;
      tick();
      check_idle_outs("w5_after");

      // read back from port 1
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'd5;
      tick();
      check("r5_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
      check("r5_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("r5_addr", {22'd0, bus.mem_address}, 32'd5);
      bus.req1 = 0;
      tick();
      check_idle_outs("r5_wait");
      tick();
      check("r5_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd2);
      check("r5_rdata", bus.rdata, 32'hAA);
      tick();
      check("r5_rvalid_off", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      check("r5_rdata_hold", bus.rdata, 32'hAA);

      // continuous tie, both writing
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'd10; bus.wdata0 = 32'h10;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'd11; bus.wdata1 = 32'h11;
      for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
         exp_port = 1'b0;
`else
         exp_port = (i % 2 == 1);
`endif
         tick();
         check("tie_gnt", {30'd0, bus.gnt1, bus.gnt0}, exp_port ? 32'd2 : 32'd1);
         check("tie_data", bus.mem_dataIn, exp_port ? 32'h11 : 32'h10);
         tick();
         check_idle_outs("tie_gap");
      end
      bus.req0 = 0; bus.req1 = 0;
      tick();

      // back-to-back reads at address extremes
      do_write(1'b0, 10'd3, 32'h3);
      do_write(1'b1, 10'd1023, 32'h3FF);
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'd3;
      tick();
      check("r3_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      bus.req0 = 0;
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'd1023;
      tick();
      check("r3_wait_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      tick();
      check("r3_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
      check("r3_rdata", bus.rdata, 32'h3);
      tick();
      check("r1023_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
      check("r1023_addr", {22'd0, bus.mem_address}, 32'd1023);
      bus.req1 = 0;
      tick();
      check("r1023_wait", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      tick();
      check("r1023_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd2);
      check("r1023_rdata", bus.rdata, 32'h3FF);
      tick();

      // reset during RDWAIT of a port-0 read
      bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'd5;
      tick();
      check("rr_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      bus.req0 = 0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check_idle_outs("async_rst");
      check("async_rst_addr",  {22'd0, bus.mem_address}, 32'd0);
      check("async_rst_rdata", bus.rdata, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      tick();
      check("post_rst_rvalid2", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      check("post_rst_rdata", bus.rdata, 32'd0);
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 10'd20; bus.wdata0 = 32'h20;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'd21; bus.wdata1 = 32'h21;
      tick();
      check("post_rst_tie", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      check("post_rst_addr", {22'd0, bus.mem_address}, 32'd20);
      bus.req0 = 0; bus.req1 = 0;
      tick();
      check_idle_outs("end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk  input  1  sole clock, rising edge active.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Ports req0/req1  input  1  access request, port 0 (CPU load/store) and port 1 (debug/DMA).
REQ-007 Ports we0/we1  input  1  write (1) / read (0) for the matching request.
REQ-008 Ports addr0/addr1  input  ADDR_W  word address per requester.
REQ-009 Ports wdata0/wdata1  input  DATA_W  write data per requester.
REQ-010 Ports gnt0/gnt1  output  1  one-cycle pulse, request accepted.
REQ-011 Ports rvalid0/rvalid1  output  1  one-cycle pulse, read data valid on rdata.
REQ-012 Port rdata  output  DATA_W  read data, shared by both requesters.
REQ-013 Ports mem_we, mem_address, mem_dataIn  output  1/ADDR_W/DATA_W  drive datamemory we/address/dataIn.
REQ-014 Port mem_dataOut  input  DATA_W  datamemory read data, valid one clock after mem_address is presented.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RDWAIT.
REQ-016 In IDLE with any req high, the FSM SHALL select a winner, latch its we/addr/wdata and move to ISSUE; otherwise remain in IDLE.
REQ-017 In ISSUE, mem_address/mem_dataIn SHALL carry the latched values, mem_we SHALL equal the latched we, and the winner's gnt SHALL be high for exactly this cycle.
REQ-018 From ISSUE, a write SHALL return to IDLE; a read SHALL go to RDWAIT.
REQ-019 In RDWAIT, rdata SHALL register mem_dataOut and the winner's rvalid SHALL pulse the following cycle; FSM SHALL return to IDLE.
REQ-020 Latency: write = 2 cycles req-to-gnt; read = gnt at cycle 2, rvalid at cycle 4 after req sampled.
REQ-021 mem_we SHALL be 0 in every state other than ISSUE-with-write.
REQ-022 Both req high in IDLE: round-robin, the port not granted last SHALL win.
REQ-023 Requesters SHALL hold req and fields stable until their gnt; req sampled only in IDLE; req dropped before sampling is ignored.
REQ-024 rdata SHALL hold its last value until the next read response.
REQ-025 gnt0 and gnt1 SHALL never be high together; likewise rvalid0/rvalid1.

Reset
REQ-026 On rst_n low, immediately: state IDLE, gnt*/rvalid* 0, mem_we 0, mem_address 0, mem_dataIn 0, rdata 0, last-grant pointer = port 1 (so port 0 wins first tie).
REQ-027 Reset asserted mid-transaction SHALL abort it with no rvalid issued and no write performed after assertion.

Configuration
REQ-028 Macro DMEM_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win ties and the last-grant pointer SHALL not exist; undefined: round-robin per REQ-022.

Structure
REQ-029 Package dmem_arb_pkg SHALL hold the FSM state enum, default ADDR_W/DATA_W constants, and port-index constants.
REQ-030 Winner selection SHALL be a sub-module dmem_rr_pick (inputs req0, req1, last; output sel, valid).

Verification
REQ-031 Reset then req0=1,we0=1,addr0=5,wdata0=0xAA -> gnt0 at cycle 2, mem_we=1 addr 5 data 0xAA in that cycle only.
REQ-032 After REQ-031, req1=1,we1=0,addr1=5 -> gnt1 pulse, then rvalid1 with rdata=0xAA, rvalid0 stays 0.
REQ-033 req0 and req1 held high continuously, both writes -> gnt order 0,1,0,1 (with DMEM_ARB_FIXED_PRIO_EN: 0,0,0,0).
REQ-034 Back-to-back reads addr 3 (port 0) then addr 1023 (port 1) after writing 3->0x3, 1023->0x3FF -> rdata 0x3 then 0x3FF, each with correct rvalid.
REQ-035 rst_n pulled low during RDWAIT -> outputs zero same cycle, no rvalid after release, next tie granted to port 0.
